// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port between a CPU (requester 0) and a loader (requester 1).
// Read data returns RD_LAT cycles after the address on a shared rdata bus with a per-requester valid pulse.
module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] D_addr,
    output logic          D_wr,
    output logic [DW-1:0] D_wdata,
    input  logic [DW-1:0] D_rdata,
    output logic          busy,
    output logic [1:0]    state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          winner;
    logic          last;
    logic          pick;
    logic          any_req;
    logic [1:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid0_q;
    logic          rvalid1_q;

    assign any_req = req0 | req1;
    // On a tie the requester not served most recently wins; a lone requester always wins.
    assign pick    = (req0 & req1) ? ~last : req1;

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = (pick ? wr1 : wr0) ? WRITE : READ;
            WRITE:   state_nxt = IDLE;
            READ:    state_nxt = RESP;
            RESP:    if (cnt == 2'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state     <= IDLE;
            winner    <= 1'b0;
            last      <= 1'b1;
            cnt       <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner  <= pick;
                        addr_q  <= pick ? addr1 : addr0;
                        wdata_q <= pick ? wdata1 : wdata0;
                    end
                end
                WRITE: last <= winner;
                READ: begin
                    last <= winner;
                    cnt  <= 2'(RD_LAT);
                end
                RESP: begin
                    cnt <= cnt - 2'd1;
                    // Memory data is valid on the last counted cycle; the valid pulse follows it.
                    if (cnt == 2'd1) begin
                        rdata_q   <= D_rdata;
                        rvalid0_q <= ~winner;
                        rvalid1_q <= winner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0      = ((state == WRITE) || (state == READ)) && !winner;
    assign gnt1      = ((state == WRITE) || (state == READ)) && winner;
    assign D_wr      = (state == WRITE);
    assign D_addr    = addr_q;
    assign D_wdata   = wdata_q;
    assign rdata     = rdata_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one RD_LAT=1 instance for arbitration and data checks,
// one RD_LAT=3 instance for long-latency reads and reset abort of an in-flight read.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RD_LAT=1 instance signals
    logic        rst1;
    logic        req0, req1, wr0, wr1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, d_wr, busy;
    logic [15:0] rdata, d_wdata, d_rdata;
    logic [7:0]  d_addr, p1;
    logic [1:0]  state_out;

    // RD_LAT=3 instance signals
    logic        rst3, r3_req;
    logic [7:0]  r3_addr, r3_d_addr, p3a, p3b, p3c;
    logic        r3_gnt0, r3_gnt1, r3_rvalid0, r3_rvalid1, r3_d_wr, r3_busy;
    logic [15:0] r3_rdata, r3_d_wdata, r3_d_rdata;
    logic [1:0]  r3_state;

    int n_checks = 0;
    int n_pass   = 0;

    acc_t        q0[$], q1[$];
    logic [15:0] rq0[$], rq1[$];
    bit          order[$];
    int          gcyc[$];
    int          dwr_cnt = 0, gnt1_cnt = 0, rv0_cnt = 0, rv3_cnt = 0, dwr3_cnt = 0;

    dmem_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) dut (
        .clk(clk), .reset(rst1),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .D_addr(d_addr), .D_wr(d_wr), .D_wdata(d_wdata),
        .D_rdata(d_rdata), .busy(busy), .state_out(state_out)
    );

    dmem_arbiter #(.AW(8), .DW(16), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst3),
        .req0(r3_req), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
        .addr0(r3_addr), .addr1(8'h00), .wdata0(16'h0000), .wdata1(16'h0000),
        .gnt0(r3_gnt0), .gnt1(r3_gnt1), .rvalid0(r3_rvalid0), .rvalid1(r3_rvalid1),
        .rdata(r3_rdata), .D_addr(r3_d_addr), .D_wr(r3_d_wr), .D_wdata(r3_d_wdata),
        .D_rdata(r3_d_rdata), .busy(r3_busy), .state_out(r3_state)
    );

    // Memory contents: a fixed pattern, with 0x0A holding 0xBEEF.
    function automatic logic [15:0] mem_fn(input logic [7:0] a);
        if (a == 8'h0A) return 16'hBEEF;
        return {a ^ 8'h5A, ~a};
    endfunction

    // Read-latency pipelines: data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        p1  <= d_addr;
        p3a <= r3_d_addr;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign d_rdata    = mem_fn(p1);
    assign r3_d_rdata = mem_fn(p3c);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic serve(input bit who);
        acc_t e;
        check(who ? "gnt1_pending" : "gnt0_pending", 32'(who ? q1.size() > 0 : q0.size() > 0), 1);
        if (who ? q1.size() > 0 : q0.size() > 0) begin
            e = who ? q1.pop_front() : q0.pop_front();
            check("gnt_dwr", 32'(d_wr), 32'(e.wr));
            check("gnt_daddr", 32'(d_addr), 32'(e.addr));
            check("gnt_state", 32'(state_out), e.wr ? 32'd1 : 32'd2);
            if (e.wr) check("gnt_dwdata", 32'(d_wdata), 32'(e.wdata));
            else if (who) rq1.push_back(mem_fn(e.addr));
            else rq0.push_back(mem_fn(e.addr));
        end
        order.push_back(who);
        gcyc.push_back(cyc);
    endtask

    task automatic retire(input bit who);
        logic [15:0] exp;
        check(who ? "rv1_pending" : "rv0_pending", 32'(who ? rq1.size() > 0 : rq0.size() > 0), 1);
        if (who ? rq1.size() > 0 : rq0.size() > 0) begin
            exp = who ? rq1.pop_front() : rq0.pop_front();
            check("rv_rdata", 32'(rdata), 32'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (!rst1) begin
            if (gnt0 || gnt1) check("single_gnt", 32'(gnt0 & gnt1), 0);
            if (gnt0) serve(1'b0);
            if (gnt1) begin serve(1'b1); gnt1_cnt++; end
            if (d_wr) begin dwr_cnt++; check("dwr_has_gnt", 32'(gnt0 | gnt1), 1); end
            if (rvalid0) begin retire(1'b0); rv0_cnt++; end
            if (rvalid1) retire(1'b1);
        end
        if (!rst3) begin
            if (r3_rvalid0 || r3_rvalid1) rv3_cnt++;
            if (r3_d_wr) dwr3_cnt++;
        end
    end

    task automatic access(input bit who, input bit w, input logic [7:0] a, input logic [15:0] d,
                          output int t_issue, output int t_gnt);
        acc_t e;
        e = '{wr: w, addr: a, wdata: d};
        if (who) begin q1.push_back(e); wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
        else     begin q0.push_back(e); wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
        t_issue = cyc;
        t_gnt   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (who ? gnt1 : gnt0) begin t_gnt = cyc; break; end
        end
        if (who) req1 = 1'b0; else req0 = 1'b0;
        check(who ? "gnt1_timeout" : "gnt0_timeout", 32'(t_gnt >= 0), 1);
    endtask

    task automatic wait_rv(input bit who, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (who ? rvalid1 : rvalid0) begin t = cyc; break; end
        end
        check("rvalid_timeout", 32'(t >= 0), 1);
    endtask

    task automatic wait_grants(input int n, input int t0);
        for (int i = 0; i < 40 && order.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("grant_count", order.size(), n);
        check("first_gnt_lat", gcyc.size() > 0 ? gcyc[0] - t0 : -1, 1);
        for (int i = 1; i < n; i++)
            if (i < gcyc.size()) check("gnt_spacing", gcyc[i] - gcyc[i-1], 2);
    endtask

    int ti, tg, tr, t0, dwr0, g1_0, rv0_0;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        r3_req = 0; r3_addr = 0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'({gnt0, gnt1}), 0);
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
        check("rst_dwr", 32'(d_wr), 0);
        check("rst_daddr", 32'(d_addr), 0);
        check("rst_dwdata", 32'(d_wdata), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(state_out), 0);
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // Single write from requester 0
        g1_0 = gnt1_cnt;
        access(1'b0, 1'b1, 8'h29, 16'h1234, ti, tg);
        check("wr_gnt_lat", tg - ti, 1);
        check("wr_busy", 32'(busy), 1);
        @(negedge clk);
        check("wr_no_gnt1", gnt1_cnt - g1_0, 0);
        check("wr_back_idle", 32'(state_out), 0);

        // Single read from requester 1 of 0x0A
        rv0_0 = rv0_cnt;
        access(1'b1, 1'b0, 8'h0A, 16'h0000, ti, tg);
        check("rd_gnt_lat", tg - ti, 1);
        wait_rv(1'b1, tr);
        check("rd_rv_lat", tr - ti, 3);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        check("rd_no_rv0", rv0_cnt - rv0_0, 0);
        @(negedge clk);
        check("rdata_hold", 32'(rdata), 32'hBEEF);

        // Tie from reset: pointer favours requester 0 first
        rst1 = 1'b1;
        @(negedge clk);
        check("rst2_daddr", 32'(d_addr), 0);
        check("rst2_rdata", 32'(rdata), 0);
        rst1 = 1'b0;
        order.delete(); gcyc.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{wr: 1'b1, addr: 8'h10, wdata: 16'h1111});
            q1.push_back('{wr: 1'b1, addr: 8'h20, wdata: 16'h2222});
        end
        wr0 = 1; addr0 = 8'h10; wdata0 = 16'h1111;
        wr1 = 1; addr1 = 8'h20; wdata1 = 16'h2222;
        req0 = 1; req1 = 1;
        t0 = cyc;
        wait_grants(4, t0);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) check("tie_order", 32'(order[i]), 32'(i % 2));

        // Lone requester 0 holding a write request
        @(negedge clk);
        order.delete(); gcyc.delete();
        dwr0 = dwr_cnt;
        for (int i = 0; i < 3; i++) q0.push_back('{wr: 1'b1, addr: 8'h31, wdata: 16'hA5A5});
        wr0 = 1; addr0 = 8'h31; wdata0 = 16'hA5A5; req0 = 1;
        t0 = cyc;
        wait_grants(3, t0);
        check("hold_dwr_pulses", dwr_cnt - dwr0, 3);

        // New request in the rvalid cycle is granted with no bubble
        @(negedge clk);
        access(1'b0, 1'b0, 8'h33, 16'h0000, ti, tg);
        wait_rv(1'b0, tr);
        access(1'b1, 1'b1, 8'h77, 16'hC0DE, ti, tg);
        check("b2b_gnt", tg - tr, 1);

        // Both requesters issuing random traffic concurrently
        @(negedge clk);
        fork
            begin
                int a, b;
                repeat (6) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    access(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), a, b);
                end
            end
            begin
                int a, b;
                repeat (6) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    access(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), a, b);
                end
            end
        join
        repeat (12) @(negedge clk);
        check("sb_drained", q0.size() + q1.size() + rq0.size() + rq1.size(), 0);

        // RD_LAT=3: full read, then a read aborted by reset
        t0 = cyc;
        r3_req = 1; r3_addr = 8'h44;
        @(negedge clk);
        check("l3_gnt", 32'(r3_gnt0), 1);
        r3_req = 0;
        tr = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r3_rvalid0) begin tr = cyc; break; end
        end
        check("l3_rv_lat", tr - t0, 5);
        check("l3_rdata", 32'(r3_rdata), 32'(mem_fn(8'h44)));
        @(negedge clk);
        rv3_cnt = 0; dwr3_cnt = 0;
        r3_req = 1; r3_addr = 8'h55;
        @(negedge clk);
        r3_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        check("l3_rst_state", 32'(r3_state), 0);
        check("l3_rst_busy", 32'(r3_busy), 0);
        check("l3_rst_rdata", 32'(r3_rdata), 0);
        check("l3_rst_daddr", 32'(r3_d_addr), 0);
        rst3 = 1'b0;
        repeat (8) @(negedge clk);
        check("l3_abort_rv", rv3_cnt, 0);
        check("l3_abort_dwr", dwr3_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8: data memory address width.
REQ-002 SHALL have parameter DW, default 16: data word width.
REQ-003 SHALL have parameter RD_LAT, default 1: memory read latency in cycles, legal range 1..3.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have ports req0, req1  input  1 each: access request from requester 0 (CPU) and requester 1 (loader).
REQ-007 SHALL have ports wr0, wr1  input  1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports addr0, addr1  input  AW each: access address.
REQ-009 SHALL have ports wdata0, wdata1  input  DW each: write data.
REQ-010 SHALL have ports gnt0, gnt1  output  1 each: one-cycle grant pulse.
REQ-011 SHALL have ports rvalid0, rvalid1  output  1 each: one-cycle read-data-valid pulse.
REQ-012 SHALL have port rdata  output  DW: returned read data, shared by both requesters.
REQ-013 SHALL have ports D_addr  output  AW, D_wr  output  1, D_wdata  output  DW: memory-side address, write enable and write data.
REQ-014 SHALL have port D_rdata  input  DW: memory read data, valid RD_LAT cycles after the address is presented.
REQ-015 SHALL have ports busy  output  1 and state_out  output  2: busy = state is not IDLE; state_out = current state encoding.

Function
REQ-016 SHALL implement states IDLE=0, WRITE=1, READ=2, RESP=3.
REQ-017 In IDLE with any req high: SHALL pick the winner, capture its wr/addr/wdata and go to WRITE (wr=1) or READ (wr=0); with no req, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted most recently wins; the last-winner pointer updates on every grant.
REQ-019 WRITE (1 cycle): D_wr=1, D_addr/D_wdata = captured values, gnt of the winner=1; next state IDLE.
REQ-020 READ (1 cycle): D_wr=0, D_addr = captured address, gnt of the winner=1; SHALL load the 2-bit counter with RD_LAT; next state RESP.
REQ-021 RESP: SHALL decrement the counter each cycle; on the cycle the counter equals 1, SHALL register rdata<=D_rdata, pulse the winner's rvalid in the following cycle and return to IDLE.
REQ-022 Latency from req seen in IDLE at cycle T: write access and gnt at T+1; read gnt at T+1; rvalid at T+2+RD_LAT.
REQ-023 rdata SHALL hold its value between rvalid pulses.
REQ-024 D_wr SHALL be 1 only in WRITE. At most one gnt SHALL be high per cycle. rvalid SHALL go only to the requester that issued the read.
REQ-025 D_addr and D_wdata SHALL hold the last captured values outside WRITE/READ.
REQ-026 A requester SHALL hold req, wr, addr and wdata stable until it sees gnt; a req still high in the IDLE cycle after gnt SHALL be treated as a new request.
REQ-027 A new request SHALL be accepted in the same IDLE cycle in which rvalid is pulsing.
REQ-028 The arbiter SHALL ignore req changes in non-IDLE states; no request SHALL be lost if its req is held.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE; gnt0/1=0, rvalid0/1=0, D_wr=0, D_addr=0, D_wdata=0, rdata=0, busy=0; the pointer SHALL be set so that requester 0 wins the first tie.
REQ-030 Reset during READ or RESP SHALL drop the in-flight read: no rvalid afterwards and no memory write.

Verification
REQ-031 Single write: req0=1, wr0=1, addr0=0x29, wdata0=0x1234 in IDLE at T -> at T+1 gnt0=1, D_wr=1, D_addr=0x29, D_wdata=0x1234; gnt1 never asserted.
REQ-032 Single read, RD_LAT=1: req1 read of addr 0x0A, memory model returns 0xBEEF -> gnt1 at T+1, rvalid1=1 with rdata=0xBEEF at T+3, rvalid0=0 throughout.
REQ-033 Tie from reset: req0 and req1 writes both held -> grants in order gnt0, gnt1, gnt0, gnt1, spaced 2 cycles apart.
REQ-034 req0 write held continuously, req1=0 -> gnt0 every 2 cycles, D_wr pulse exactly once per grant.
REQ-035 RD_LAT=3 read at T -> rvalid at T+5; repeat with reset=1 at T+3 -> outputs at reset values at T+4, no rvalid.
REQ-036 A new request issued in the IDLE cycle where rvalid pulses -> granted on the next cycle with no idle bubble.
